axil_irq_ctrl: RTL and testbench
================================

// Module: axil_irq_ctrl
// PURPOSE
//   Parametrised AXI4-Lite control slave for a partition's interrupt lines.
//   Drives NUM_IRQ irq_req outputs from set/clear/write registers and counts irq_ack pulses per channel.
//   Optional per-channel auto-clear on ack; decoupled AW/W acceptance; SLVERR on unmapped addresses.
//   Sits between the partition's CTL AXI-Lite port and its irq_req/irq_ack pins.
// PARAMETERS
//   NUM_IRQ  16  interrupt channels, 1..32
//   CNT_W    32  ack counter width, 1..32; zero-extended on read
//   ADDR_W   8   AXI-Lite address width; only addr[7:2] decoded, upper bits ignored
// PORTS
//   clk                      in   1        clock
//   resetn                   in   1        synchronous active-low reset
//   s_axil_awaddr/awvalid    in   ADDR_W/1 write address, valid
//   s_axil_awready           out  1
//   s_axil_wdata/wstrb       in   32/4     write data, byte strobes
//   s_axil_wvalid            in   1
//   s_axil_wready            out  1
//   s_axil_bresp/bvalid      out  2/1      write response
//   s_axil_bready            in   1
//   s_axil_araddr/arvalid    in   ADDR_W/1 read address, valid
//   s_axil_arready           out  1
//   s_axil_rdata/rresp       out  32/2     read data, response
//   s_axil_rvalid            out  1
//   s_axil_rready            in   1
//   irq_req                  out  NUM_IRQ  interrupt request levels
//   irq_ack                  in   NUM_IRQ  one-cycle ack pulses, one per ack
// BEHAVIOUR
//   Register map (word = addr[7:2]):
//     0x00+4i (i<NUM_IRQ)  CNT[i]: read ack count; any write with wstrb!=0 clears it
//     0x80  REQ   R/W irq_req, byte-strobed; bits >= NUM_IRQ read 0, writes ignored
//     0x84  SET   W1S irq_req; reads 0
//     0x88  CLR   W1C irq_req; reads 0
//     0x8C  MODE  R/W; bit i=1 -> irq_ack[i] clears irq_req[i]
//     other (incl. CNT i>=NUM_IRQ) -> OKAY reads as 0? no: rresp/bresp=2'b10 SLVERR, rdata=0, no side effect
//   Reset: irq_req, MODE, all CNT = 0; rvalid=bvalid=0; awready=wready=arready=1; rdata=0, rresp=bresp=0.
//   Read: arready = !rvalid. AR handshake -> next cycle rvalid=1, rdata/rresp registered; held stable until rready.
//     rdata samples state of handshake cycle (pre-update values).
//   Write: AW and W accepted independently, in either order or same cycle, into one-entry holding regs.
//     awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
//     Once both held (or both handshaking now) -> register update that cycle, bvalid=1 next cycle,
//     holds cleared; bvalid clears on bready. Max one write outstanding.
//   Counters: CNT[i] += irq_ack[i] each cycle; wraps 2^CNT_W-1 -> 0.
//     Clear write + ack same cycle -> CNT[i] = 1.
//   irq_req priority per bit, same cycle: register write (REQ/SET/CLR) > auto-clear ack > hold.
//   Read and write paths operate concurrently; no interlock between them.
//   resetn low mid-transaction: outstanding R/B responses and held AW/W dropped; master must also reset.
// TESTING
//   Reset, read 0x80 -> rdata=0, rresp=0; read 0x00 -> 0; arready=awready=wready=1.
//   W at cycle 0, AW at cycle 3 to 0x84 data 0x5 -> bvalid cycle 4, irq_req=0x0005; read 0x80 -> 0x5.
//   MODE=0x1, irq_req=0x3, pulse irq_ack[0] x3 -> irq_req=0x2, CNT[0]=3; CNT[1]=0.
//   CNT_W=4: 17 acks on ch 2 -> read 0x08 = 1; write 0x08 with ack same cycle -> reads 1.
//   Read 0x90, write 0x90 -> rresp=bresp=2'b10, rdata=0, irq_req unchanged.
//   Hold rready=0 two cycles: rdata stable, arready=0; new ar accepted cycle after rready handshake.

Source files
------------

// File: rtl/axil_irq_ctrl.sv
// axil_irq_ctrl
//   AXI4-Lite control slave for a partition's interrupt lines. It holds NUM_IRQ
//   interrupt request levels that software drives through the REQ, SET and CLR
//   registers. It counts irq_ack pulses per channel, and it can optionally drop
//   a request when that channel is acknowledged (MODE register).
//
//   Register map (word index = addr[7:2]):
//     0x00+4i  CNT[i]  ack count, read; a write with any strobe clears it
//     0x80     REQ     irq_req, R/W, byte-strobed
//     0x84     SET     write-1-to-set irq_req, reads 0
//     0x88     CLR     write-1-to-clear irq_req, reads 0
//     0x8C     MODE    R/W, bit i=1 lets irq_ack[i] clear irq_req[i]
//     other            SLVERR, read data 0, no side effect
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   s_axil_aw* / w* / b*        AXI-Lite write address, data and response
//   s_axil_ar* / r*             AXI-Lite read address and data
//   irq_req                     interrupt request levels
//   irq_ack                     one-cycle acknowledge pulses, one per ack
module axil_irq_ctrl #(
  parameter int NUM_IRQ = 16,
  parameter int CNT_W   = 32,
  parameter int ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   s_axil_awaddr,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [31:0]         s_axil_wdata,
  input  logic [3:0]          s_axil_wstrb,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  output logic [1:0]          s_axil_bresp,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  input  logic [ADDR_W-1:0]   s_axil_araddr,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  output logic [31:0]         s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic [NUM_IRQ-1:0]  irq_req,
  input  logic [NUM_IRQ-1:0]  irq_ack
);

  localparam logic [5:0] W_REQ  = 6'd32;
  localparam logic [5:0] W_SET  = 6'd33;
  localparam logic [5:0] W_CLR  = 6'd34;
  localparam logic [5:0] W_MODE = 6'd35;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // state
  logic [NUM_IRQ-1:0] req_q, req_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q [NUM_IRQ];
  logic [CNT_W-1:0]   cnt_d [NUM_IRQ];

  // write channel holding registers
  logic        aw_held_q, aw_held_d;
  logic [5:0]  aw_word_q, aw_word_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  // read channel
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs, do_write;
  logic [5:0]  wr_word, rd_word;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] strb_mask;
  logic [31:0] req_w, mode_w;
  logic [NUM_IRQ-1:0] cnt_clr;
  logic        wr_err;
  logic [31:0] rd_data_c;
  logic        rd_err_c;

  // only addr[7:2] is decoded
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

  assign s_axil_awready = !aw_held_q && !bvalid_q;
  assign s_axil_wready  = !w_held_q && !bvalid_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign irq_req        = req_q;

  assign aw_hs    = s_axil_awvalid && s_axil_awready;
  assign w_hs     = s_axil_wvalid && s_axil_wready;
  assign ar_hs    = s_axil_arvalid && s_axil_arready;
  // A write commits in the cycle both halves are available, held or live.
  assign do_write = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_word  = aw_held_q ? aw_word_q : s_axil_awaddr[7:2];
  assign wr_data  = w_held_q ? wdata_q : s_axil_wdata;
  assign wr_strb  = w_held_q ? wstrb_q : s_axil_wstrb;
  assign rd_word  = s_axil_araddr[7:2];

  assign strb_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

  // Register write decode. The auto-clear from irq_ack is applied first, so a
  // register write to the same bit in the same cycle overrides it.
  always_comb begin
    req_w   = 32'(req_q & ~(mode_q & irq_ack));
    mode_w  = 32'(mode_q);
    cnt_clr = '0;
    wr_err  = 1'b1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr_word == 6'(i)) begin
        wr_err     = 1'b0;
        cnt_clr[i] = do_write && (|wr_strb);
      end
    end
    case (wr_word)
      W_REQ: begin
        wr_err = 1'b0;
        if (do_write) req_w = (req_w & ~strb_mask) | (wr_data & strb_mask);
      end
      W_SET: begin
        wr_err = 1'b0;
        if (do_write) req_w = req_w | (wr_data & strb_mask);
      end
      W_CLR: begin
        wr_err = 1'b0;
        if (do_write) req_w = req_w & ~(wr_data & strb_mask);
      end
      W_MODE: begin
        wr_err = 1'b0;
        if (do_write) mode_w = (mode_w & ~strb_mask) | (wr_data & strb_mask);
      end
      default: ;
    endcase
    req_d  = req_w[NUM_IRQ-1:0];
    mode_d = mode_w[NUM_IRQ-1:0];
  end

  // Ack counters; a clear in the same cycle as an ack leaves the count at 1.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cnt_clr[i]) cnt_d[i] = CNT_W'(irq_ack[i]);
      else            cnt_d[i] = cnt_q[i] + CNT_W'(irq_ack[i]);
    end
  end

  // Read decode samples current (pre-update) state.
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (rd_word == 6'(i)) begin
        rd_data_c = 32'(cnt_q[i]);
        rd_err_c  = 1'b0;
      end
    end
    case (rd_word)
      W_REQ:  begin rd_data_c = 32'(req_q);  rd_err_c = 1'b0; end
      W_SET:  rd_err_c = 1'b0;
      W_CLR:  rd_err_c = 1'b0;
      W_MODE: begin rd_data_c = 32'(mode_q); rd_err_c = 1'b0; end
      default: ;
    endcase
  end

  // Channel handshake bookkeeping.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_word_d = aw_word_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_word_d = s_axil_awaddr[7:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (do_write) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
    end

    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_c;
      rresp_d  = rd_err_c ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q     <= '0;
      mode_q    <= '0;
      for (int i = 0; i < NUM_IRQ; i++) cnt_q[i] <= '0;
      aw_held_q <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      req_q     <= req_d;
      mode_q    <= mode_d;
      for (int i = 0; i < NUM_IRQ; i++) cnt_q[i] <= cnt_d[i];
      aw_held_q <= aw_held_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_irq_ctrl.sv
module tb_axil_irq_ctrl;

  localparam int NUM_IRQ = 16;
  localparam int CNT_W   = 4;
  localparam int ADDR_W  = 8;

  logic                clk = 1'b0;
  logic                resetn;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [NUM_IRQ-1:0]  irq_req;
  logic [NUM_IRQ-1:0]  irq_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] exp_rd_q [$];
  logic [1:0]  exp_b_q  [$];

  always #5 clk = ~clk;

  axil_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .irq_req        (irq_req),
    .irq_ack        (irq_ack)
  );

  task automatic check_val(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: pop expectations as responses complete
  always @(negedge clk) begin
    if (resetn && rvalid && rready) begin
      if (exp_rd_q.size() == 0) check_val("rd_unexpected", 34'd1, 34'd0);
      else check_val("rd_resp_data", {rresp, rdata}, exp_rd_q.pop_front());
    end
    if (resetn && bvalid && bready) begin
      if (exp_b_q.size() == 0) check_val("b_unexpected", 34'd1, 34'd0);
      else check_val("bresp", 34'(bresp), 34'(exp_b_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int c = 0;
    exp_rd_q.push_back({exp_r, exp_d});
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && c < 50) begin tick(); c++; end
    if (!arready) check_val("ar_timeout", 34'd1, 34'd0);
    tick();
    arvalid = 1'b0;
    c = 0;
    while (rvalid && c < 50) begin tick(); c++; end
    if (rvalid) check_val("r_timeout", 34'd1, 34'd0);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input logic [1:0] exp_b,
                           output int b_cyc);
    int c = 0;
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    b_cyc = -1;
    exp_b_q.push_back(exp_b);
    while (!(aw_done && w_done) && c < 50) begin
      if (c == aw_dly) begin awaddr = a; awvalid = 1'b1; end
      if (c == w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick();
      c++;
      if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
      if (w_now)  begin w_done = 1;  wvalid = 1'b0; end
      if (bvalid && b_cyc < 0) b_cyc = c;
      if (w_done && !aw_done) check_val("wready_while_held", 34'(wready), 34'd0);
      if (aw_done && !w_done) check_val("awready_while_held", 34'(awready), 34'd0);
    end
    if (!(aw_done && w_done)) check_val("wr_hs_timeout", 34'd1, 34'd0);
    while (b_cyc < 0 && c < 60) begin
      tick();
      c++;
      if (bvalid) b_cyc = c;
    end
    if (b_cyc < 0) check_val("b_timeout", 34'd1, 34'd0);
    while (bvalid && c < 70) begin tick(); c++; end
  endtask

  task automatic pulse_ack(input int ch, input int n);
    irq_ack = NUM_IRQ'(1) << ch;
    repeat (n) tick();
    irq_ack = '0;
  endtask

  int bc;

  initial begin
    resetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; irq_ack = '0;
    repeat (3) tick();
    resetn = 1'b1;

    // reset state
    check_val("rst_arready", 34'(arready), 34'd1);
    check_val("rst_awready", 34'(awready), 34'd1);
    check_val("rst_wready", 34'(wready), 34'd1);
    check_val("rst_rvalid", 34'(rvalid), 34'd0);
    check_val("rst_bvalid", 34'(bvalid), 34'd0);
    check_val("rst_irq_req", 34'(irq_req), 34'd0);
    check_val("rst_rdata_rresp", {rresp, rdata}, 34'd0);
    check_val("rst_bresp", 34'(bresp), 34'd0);
    axi_read(8'h80, 32'h0, 2'b00);
    axi_read(8'h00, 32'h0, 2'b00);

    // W first, AW three cycles later, to SET
    axi_write(8'h84, 32'h5, 4'hF, 3, 0, 2'b00, bc);
    check_val("b_latency", 34'(bc), 34'd4);
    check_val("irq_after_set", 34'(irq_req), 34'h5);
    axi_read(8'h80, 32'h5, 2'b00);

    // MODE same-cycle AW/W, REQ with AW first
    axi_write(8'h8C, 32'h1, 4'hF, 0, 0, 2'b00, bc);
    axi_read(8'h8C, 32'h1, 2'b00);
    axi_write(8'h80, 32'h3, 4'hF, 0, 2, 2'b00, bc);
    check_val("irq_after_req", 34'(irq_req), 34'h3);

    // auto-clear and counting
    pulse_ack(0, 3);
    check_val("irq_after_ack0", 34'(irq_req), 34'h2);
    axi_read(8'h00, 32'd3, 2'b00);
    axi_read(8'h04, 32'd0, 2'b00);

    // CNT clear needs a strobe
    axi_write(8'h00, 32'h0, 4'h0, 0, 0, 2'b00, bc);
    axi_read(8'h00, 32'd3, 2'b00);
    axi_write(8'h00, 32'h0, 4'hF, 0, 0, 2'b00, bc);
    axi_read(8'h00, 32'd0, 2'b00);

    // byte strobes on REQ, bits above NUM_IRQ ignored
    axi_write(8'h80, 32'hFFFF_FFFF, 4'b0010, 0, 0, 2'b00, bc);
    check_val("irq_strobed", 34'(irq_req), 34'hFF02);
    axi_read(8'h80, 32'hFF02, 2'b00);
    axi_write(8'h88, 32'h0000_FF00, 4'hF, 1, 0, 2'b00, bc);
    check_val("irq_after_clr", 34'(irq_req), 34'h2);
    axi_read(8'h84, 32'h0, 2'b00);
    axi_read(8'h88, 32'h0, 2'b00);

    // 4-bit counter wrap: 17 acks -> 1
    pulse_ack(2, 17);
    axi_read(8'h08, 32'd1, 2'b00);
    check_val("irq_no_autoclr_ch2", 34'(irq_req), 34'h2);

    // clear with ack in the same cycle -> 1
    fork
      begin irq_ack = 16'h0004; tick(); irq_ack = '0; end
    join_none
    axi_write(8'h08, 32'h0, 4'hF, 0, 0, 2'b00, bc);
    axi_read(8'h08, 32'd1, 2'b00);

    // SET beats auto-clear ack on the same bit
    fork
      begin irq_ack = 16'h0001; tick(); irq_ack = '0; end
    join_none
    axi_write(8'h84, 32'h1, 4'hF, 0, 0, 2'b00, bc);
    check_val("irq_set_beats_ack", 34'(irq_req), 34'h3);
    axi_read(8'h00, 32'd1, 2'b00);

    // unmapped addresses
    axi_read(8'h90, 32'h0, 2'b10);
    axi_read(8'h40, 32'h0, 2'b10);
    axi_read(8'hFC, 32'h0, 2'b10);
    axi_write(8'h90, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, bc);
    axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, bc);
    check_val("irq_after_slverr", 34'(irq_req), 34'h3);

    // back-pressure on R: data stays stable while state underneath changes
    rready  = 1'b0;
    exp_rd_q.push_back({2'b00, 32'h3});
    araddr  = 8'h80;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    irq_ack = 16'h0001;
    check_val("hold1_rdata", 34'(rdata), 34'h3);
    check_val("hold1_arready", 34'(arready), 34'd0);
    tick();
    irq_ack = '0;
    check_val("hold2_rdata", 34'(rdata), 34'h3);
    check_val("hold2_rvalid", 34'(rvalid), 34'd1);
    check_val("hold2_arready", 34'(arready), 34'd0);
    check_val("irq_ack_during_hold", 34'(irq_req), 34'h2);
    rready = 1'b1;
    tick();
    check_val("after_rhs_rvalid", 34'(rvalid), 34'd0);
    check_val("after_rhs_arready", 34'(arready), 34'd1);
    axi_read(8'h80, 32'h2, 2'b00);

    repeat (2) tick();
    check_val("rd_queue_drained", 34'(exp_rd_q.size()), 34'd0);
    check_val("b_queue_drained", 34'(exp_b_q.size()), 34'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
